// File: rtl/matmul_feeder_if.sv
// Operand stream into the matmul feeder: one input-matrix row plus two
// weight elements per beat, with a valid/ready handshake.
interface matmul_feeder_if #(
    parameter int DATA_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [16*DATA_W-1:0]   in_row;
    logic [2*DATA_W-1:0]    in_wgt;

    // Operand source side
    modport master (
        output in_valid,
        output in_row,
        output in_wgt,
        input  in_ready
    );

    // Feeder side
    modport slave (
        input  in_valid,
        input  in_row,
        input  in_wgt,
        output in_ready
    );
endinterface

// File: rtl/matmul_feeder.sv
// Matmul feeder: streams cfg_k_len+1 operand beats into the PE array,
// waits PE_LAT cycles for the accumulator to settle, issues one round
// cycle and then a one-cycle done pulse. All outputs are registered.
module matmul_feeder #(
    parameter int PE_LAT = 2,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3:0]            cfg_k_len,
    input  logic [3:0]            cfg_acc_sel,
    input  logic [3:0]            cfg_round_sel,
    matmul_feeder_if.slave        in_bus,
    output logic [16*DATA_W-1:0]  data_input_matrix,
    output logic [2*DATA_W-1:0]   data_weight_matrix,
    output logic                  mac_en,
    output logic                  acc_clr,
    output logic [3:0]            add_number,
    output logic [3:0]            rounder_number,
    output logic                  rounder_en,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT,
        ROUND,
        DONE
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(PE_LAT);

    state_t      state;
    logic        ready_q;
    logic [3:0]  beat_cnt;
    logic [3:0]  k_len;
    logic [2:0]  wait_cnt;
    logic        beat_fire;

    assign in_bus.in_ready = ready_q;

    // A beat offered in an abort cycle is never taken.
    assign beat_fire = in_bus.in_valid & ready_q & ~abort;

    // Job sequencer: state, counters, latched config and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            ready_q            <= 1'b0;
            beat_cnt           <= '0;
            k_len              <= '0;
            wait_cnt           <= '0;
            data_input_matrix  <= '0;
            data_weight_matrix <= '0;
            mac_en             <= 1'b0;
            acc_clr            <= 1'b0;
            add_number         <= '0;
            rounder_number     <= '0;
            rounder_en         <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            mac_en     <= 1'b0;
            acc_clr    <= 1'b0;
            rounder_en <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                ready_q <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state          <= STREAM;
                            ready_q        <= 1'b1;
                            busy           <= 1'b1;
                            beat_cnt       <= '0;
                            k_len          <= cfg_k_len;
                            add_number     <= cfg_acc_sel;
                            rounder_number <= cfg_round_sel;
                        end
                    end
                    STREAM: begin
                        if (beat_fire) begin
                            data_input_matrix  <= in_bus.in_row;
                            data_weight_matrix <= in_bus.in_wgt;
                            mac_en             <= 1'b1;
                            acc_clr            <= (beat_cnt == 4'd0);
                            beat_cnt           <= beat_cnt + 4'd1;
                            if (beat_cnt == k_len) begin
                                state    <= WAIT;
                                ready_q  <= 1'b0;
                                wait_cnt <= WAIT_LOAD;
                            end
                        end
                    end
                    WAIT: begin
                        if (wait_cnt == 3'd0) begin
                            state      <= ROUND;
                            rounder_en <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 3'd1;
                        end
                    end
                    ROUND: begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        ready_q <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matmul_feeder.sv
// Self-checking bench for matmul_feeder: a timeline model of the job
// (beat queue, scheduled round/done cycles) checked every cycle, plus
// hand-computed latency and count expectations per scenario.
module tb_matmul_feeder;

    localparam int PE_LAT = 2;
    localparam int DATA_W = 16;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [3:0]            cfg_k_len;
    logic [3:0]            cfg_acc_sel;
    logic [3:0]            cfg_round_sel;
    logic [16*DATA_W-1:0]  data_input_matrix;
    logic [2*DATA_W-1:0]   data_weight_matrix;
    logic                  mac_en;
    logic                  acc_clr;
    logic [3:0]            add_number;
    logic [3:0]            rounder_number;
    logic                  rounder_en;
    logic                  busy;
    logic                  done;

    matmul_feeder_if #(.DATA_W(DATA_W)) bus ();

    matmul_feeder #(.PE_LAT(PE_LAT), .DATA_W(DATA_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .abort              (abort),
        .cfg_k_len          (cfg_k_len),
        .cfg_acc_sel        (cfg_acc_sel),
        .cfg_round_sel      (cfg_round_sel),
        .in_bus             (bus.slave),
        .data_input_matrix  (data_input_matrix),
        .data_weight_matrix (data_weight_matrix),
        .mac_en             (mac_en),
        .acc_clr            (acc_clr),
        .add_number         (add_number),
        .rounder_number     (rounder_number),
        .rounder_en         (rounder_en),
        .busy               (busy),
        .done               (done)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- timeline model ----------------
    int           cyc;
    bit           m_active, m_stream;
    int           m_beats, m_k, m_rnd_at, m_done_at;
    logic [255:0] m_row;
    logic [31:0]  m_wgt;
    logic [3:0]   m_acc, m_rsel;
    bit           m_mac, m_clr, m_ready, m_busy, m_rnden, m_done;

    task automatic model_step();
        int prev;
        if (!rst_n) begin
            cyc = 0; m_active = 0; m_stream = 0; m_beats = 0; m_k = 0;
            m_rnd_at = -1; m_done_at = -1; m_row = '0; m_wgt = '0;
            m_acc = '0; m_rsel = '0; m_mac = 0; m_clr = 0;
            m_ready = 0; m_busy = 0; m_rnden = 0; m_done = 0;
            return;
        end
        prev  = cyc;
        m_mac = 0;
        m_clr = 0;
        if (abort) begin
            m_active = 0; m_stream = 0; m_rnd_at = -1; m_done_at = -1;
        end else if (m_active) begin
            if (m_stream && bus.in_valid) begin
                m_mac = 1;
                m_clr = (m_beats == 0);
                m_row = bus.in_row;
                m_wgt = bus.in_wgt;
                m_beats++;
                if (m_beats == m_k + 1) begin
                    // last beat at prev: WAIT spans PE_LAT+1 cycles, then ROUND, DONE
                    m_stream  = 0;
                    m_rnd_at  = prev + PE_LAT + 2;
                    m_done_at = prev + PE_LAT + 3;
                end
            end
            if (prev == m_done_at) m_active = 0;
        end else if (start) begin
            m_active = 1; m_stream = 1; m_beats = 0; m_k = int'(cfg_k_len);
            m_acc = cfg_acc_sel; m_rsel = cfg_round_sel;
            m_rnd_at = -1; m_done_at = -1;
        end
        cyc     = prev + 1;
        m_ready = m_stream;
        m_busy  = m_active;
        m_rnden = (cyc == m_rnd_at);
        m_done  = (cyc == m_done_at);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("in_ready",   256'(bus.in_ready),      256'(m_ready));
                chk("mac_en",     256'(mac_en),            256'(m_mac));
                chk("acc_clr",    256'(acc_clr),           256'(m_clr));
                chk("rounder_en", 256'(rounder_en),        256'(m_rnden));
                chk("done",       256'(done),              256'(m_done));
                chk("busy",       256'(busy),              256'(m_busy));
                chk("add_number", 256'(add_number),        256'(m_acc));
                chk("round_num",  256'(rounder_number),    256'(m_rsel));
                chk("row_data",   data_input_matrix,       m_row);
                chk("wgt_data",   256'(data_weight_matrix), 256'(m_wgt));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_data();
        for (int unsigned i = 0; i < 8; i++) bus.in_row[i*32 +: 32] = $urandom;
        bus.in_wgt = $urandom;
    endtask

    // Drives start for one cycle; returns in the cycle after the start cycle.
    task automatic start_job(input logic [3:0] k, input logic [3:0] a, input logic [3:0] r);
        cfg_k_len = k; cfg_acc_sel = a; cfg_round_sel = r;
        start = 1'b1; bus.in_valid = 1'b1; new_data();
        step();
        start = 1'b0;
        cfg_k_len = 4'hF; cfg_acc_sel = 4'hF; cfg_round_sel = 4'hF;
        new_data();
    endtask

    // Runs until done (n = cycles since the start cycle); bounded by limit.
    task automatic wait_job(input bit toggle, input int limit,
                            output int done_n, output int rnd_n, output int macs);
        int n;
        n = 1; done_n = -1; rnd_n = -1; macs = 0;
        while (n <= limit) begin
            if (mac_en) macs++;
            if (rounder_en) rnd_n = n;
            if (done) begin
                done_n = n;
                break;
            end
            new_data();
            bus.in_valid = toggle ? (((n + 1) % 2) == 1) : 1'b1;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        if (done_n < 0) begin
            tests++;
            fails++;
            $display("FAIL job_timeout: no done within %0d cycles", limit);
        end
    endtask

    int dn, rn, mc, cnt;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_k_len = '0; cfg_acc_sel = '0; cfg_round_sel = '0;
        bus.in_valid = 1'b0; bus.in_row = '0; bus.in_wgt = '0;
        step(); step();
        chk("rst_busy",     256'(busy),              256'(0));
        chk("rst_in_ready", 256'(bus.in_ready),      256'(0));
        chk("rst_row",      data_input_matrix,       256'(0));
        chk("rst_add",      256'(add_number),        256'(0));
        chk_en = 1;
        rst_n = 1'b1;
        step();

        // k_len=3, acc 5, round 2: rounder at 8, done at 9
        start_job(4'd3, 4'd5, 4'd2);
        wait_job(1'b0, 40, dn, rn, mc);
        chk("A_done_cycle", 256'(dn), 256'(9));
        chk("A_rnd_cycle",  256'(rn), 256'(8));
        chk("A_mac_count",  256'(mc), 256'(4));
        chk("A_add_number", 256'(add_number), 256'(5));
        chk("A_round_num",  256'(rounder_number), 256'(2));
        step(); step();

        // k_len=15 with in_valid toggling
        start_job(4'd15, 4'd1, 4'd7);
        wait_job(1'b1, 80, dn, rn, mc);
        chk("B_mac_count", 256'(mc), 256'(16));
        step();

        // start during STREAM ignored; start right after DONE honoured
        start_job(4'd7, 4'd3, 4'd4);
        step();
        cfg_k_len = 4'd0; cfg_acc_sel = 4'd9; cfg_round_sel = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        chk("C_add_kept",   256'(add_number),     256'(3));
        chk("C_round_kept", 256'(rounder_number), 256'(4));
        wait_job(1'b0, 40, dn, rn, mc);
        step();
        start_job(4'd0, 4'd6, 4'd1);
        chk("C_restart_busy", 256'(busy),       256'(1));
        chk("C_restart_add",  256'(add_number), 256'(6));
        wait_job(1'b0, 40, dn, rn, mc);
        chk("C_k0_done_cycle", 256'(dn), 256'(PE_LAT + 4));
        chk("C_k0_mac_count",  256'(mc), 256'(1));
        step();

        // abort during WAIT
        start_job(4'd1, 4'd2, 4'd3);
        bus.in_valid = 1'b1;
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("D_busy_after_abort", 256'(busy), 256'(0));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (rounder_en || done) cnt++;
            step();
        end
        chk("D_no_round_done", 256'(cnt), 256'(0));

        // abort and start together: abort wins
        cfg_k_len = 4'd2; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("D_abort_beats_start", 256'(busy), 256'(0));

        // abort during STREAM with a beat on offer
        start_job(4'd3, 4'd4, 4'd5);
        step();
        bus.in_valid = 1'b1; abort = 1'b1;
        step();
        abort = 1'b0; bus.in_valid = 1'b0;
        chk("D_abort_no_mac",  256'(mac_en), 256'(0));
        chk("D_abort_no_busy", 256'(busy),   256'(0));

        // normal job after aborts
        start_job(4'd2, 4'd8, 4'd6);
        wait_job(1'b0, 40, dn, rn, mc);
        chk("D_after_done_cycle", 256'(dn), 256'(3 + PE_LAT + 3));
        step();

        // reset while beat 2 is on offer
        start_job(4'd5, 4'd7, 4'd7);
        bus.in_valid = 1'b1;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("E_async_mac",   256'(mac_en),            256'(0));
        chk("E_async_busy",  256'(busy),              256'(0));
        chk("E_async_row",   data_input_matrix,       256'(0));
        chk("E_async_ready", 256'(bus.in_ready),      256'(0));
        chk("E_async_add",   256'(add_number),        256'(0));
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("E_post_ready", 256'(bus.in_ready), 256'(0));
        chk("E_post_busy",  256'(busy),         256'(0));
        bus.in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matmul_feeder.md
MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 The block SHALL have parameter PE_LAT, default 2, meaning cycles from the last MAC beat until the accumulator result is stable for rounding (1..7).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the width of one fixed-point element (Q7.9).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a job; honoured only in IDLE.
REQ-006 The block SHALL have port abort  input  1  synchronous job cancel.
REQ-007 The block SHALL have port cfg_k_len  input  4  number of MAC beats minus 1 (0 means 1 beat, 15 means 16 beats).
REQ-008 The block SHALL have port cfg_acc_sel  input  4  accumulator register select for the job.
REQ-009 The block SHALL have port cfg_round_sel  input  4  round-format select for the job.
REQ-010 The block SHALL have port in_valid  input  1  operand beat valid.
REQ-011 The block SHALL have port in_ready  output  1  operand beat accepted when in_valid and in_ready are both 1.
REQ-012 The block SHALL have port in_row  input  16*DATA_W  16 input-matrix elements, element i at bits [i*16 +: 16].
REQ-013 The block SHALL have port in_wgt  input  2*DATA_W  2 weight elements, element j at bits [j*16 +: 16].
REQ-014 The block SHALL have port data_input_matrix  output  16*DATA_W  registered row to the PE array.
REQ-015 The block SHALL have port data_weight_matrix  output  2*DATA_W  registered weights to the PE array.
REQ-016 The block SHALL have port mac_en  output  1  PE array multiplies and accumulates this cycle.
REQ-017 The block SHALL have port acc_clr  output  1  first beat of a job; the PE array overwrites the accumulator instead of adding.
REQ-018 The block SHALL have port add_number  output  4  accumulator select.
REQ-019 The block SHALL have port rounder_number  output  4  round select.
REQ-020 The block SHALL have port rounder_en  output  1  PE array rounds the selected accumulator this cycle.
REQ-021 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-022 The block SHALL have port done  output  1  one-cycle job-complete pulse.

Function
REQ-023 The block SHALL implement the states IDLE, STREAM, WAIT, ROUND and DONE.
REQ-024 In IDLE, when start=1, the block SHALL latch cfg_* and go to STREAM with beat counter=0; start in any other state SHALL be ignored.
REQ-025 In STREAM, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-026 On each accepted beat, the block SHALL register in_row and in_wgt into data_input_matrix and data_weight_matrix next cycle, with mac_en=1 for exactly that cycle; acc_clr SHALL be 1 only with beat 0.
REQ-027 No accepted beat SHALL mean mac_en=0, with data outputs holding their last value (stall, no bubble insertion).
REQ-028 When beat number cfg_k_len is accepted, the block SHALL go to WAIT, load a wait counter with PE_LAT, and decrement it each cycle; at 0 it SHALL go to ROUND.
REQ-029 ROUND SHALL last exactly 1 cycle with rounder_en=1; the next state SHALL be DONE.
REQ-030 DONE SHALL last exactly 1 cycle with done=1; the next state SHALL be IDLE, so a start in the cycle after DONE is honoured.
REQ-031 add_number and rounder_number SHALL equal the latched cfg_acc_sel and cfg_round_sel from the start cycle through DONE, and SHALL hold their value in IDLE.
REQ-032 abort=1 in any state SHALL force IDLE next cycle with mac_en, acc_clr, rounder_en and done at 0 and no done pulse; a beat presented in the abort cycle SHALL NOT be accepted.
REQ-033 abort and start in the same cycle SHALL resolve with abort winning.
REQ-034 Minimum job latency, from the start cycle to done, SHALL be (cfg_k_len+1) + PE_LAT + 3 cycles with in_valid held at 1.

Reset
REQ-035 While rst_n=0, all outputs SHALL be 0 and the state SHALL be IDLE, immediately and independent of clk.
REQ-036 Reset asserted mid-job SHALL discard the job; after release the block SHALL wait for a new start.

Verification
REQ-037 Scenario: start, k_len=3, acc_sel=5, round_sel=2, in_valid held 1 -> 4 mac_en cycles with acc_clr on the first only; add_number=5; rounder_en at cycle 4+PE_LAT+2; done 1 cycle later.
REQ-038 Scenario: k_len=15 with in_valid toggling 1/0 -> exactly 16 mac_en pulses, each carrying the accepted row and weights in order; no mac_en on stall cycles.
REQ-039 Scenario: abort during WAIT -> no rounder_en, no done, busy=0 next cycle; a following job runs normally.
REQ-040 Scenario: rst_n low during beat 2 -> outputs 0 asynchronously; after release in_ready=0 until start.
REQ-041 Scenario: start during STREAM -> ignored, cfg unchanged; start in the cycle after DONE -> accepted.
REQ-042 Scenario: k_len=0 -> single beat with mac_en=acc_clr=1; done at cycle PE_LAT+4 after start.
